// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake and a two-entry (main + skid) buffer.
// Optional stall cycle counter enabled by defining MEMWB_STALL_CNT_EN.
module mem_wb_skid #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              mem_valid,
    output logic              mem_ready,
    input  logic [ADDR_W-1:0] mem_wd,
    input  logic              mem_wreg,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_hi,
    input  logic [DATA_W-1:0] mem_lo,
    input  logic              mem_whilo,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [ADDR_W-1:0] wb_wd,
    output logic              wb_wreg,
    output logic [DATA_W-1:0] wb_wdata,
    output logic [DATA_W-1:0] wb_hi,
    output logic [DATA_W-1:0] wb_lo,
    output logic              wb_whilo,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic [ADDR_W-1:0] wd;
        logic              wreg;
        logic [DATA_W-1:0] wdata;
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
        logic              whilo;
    } beat_t;

    beat_t main_q, main_d;
    beat_t skid_q, skid_d;
    logic  main_v_q, main_v_d;
    logic  skid_v_q, skid_v_d;
    beat_t mem_beat;
    logic  in_fire, out_fire;

    assign mem_beat = '{wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                        hi: mem_hi, lo: mem_lo, whilo: mem_whilo};

    assign mem_ready = !skid_v_q && !flush && !rst;
    assign in_fire   = mem_valid && mem_ready;
    assign out_fire  = main_v_q && wb_ready;

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        if (flush) begin
            main_d   = '0;
            skid_d   = '0;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || out_fire) begin
            // main is free this edge: skid drains first to keep FIFO order
            if (skid_v_q) begin
                main_d   = skid_q;
                main_v_d = 1'b1;
                skid_v_d = 1'b0;
            end else if (in_fire) begin
                main_d   = mem_beat;
                main_v_d = 1'b1;
            end else begin
                main_d   = '0;
                main_v_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_d   = mem_beat;
            skid_v_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign wb_valid = main_v_q;
    assign wb_wd    = main_q.wd;
    assign wb_wreg  = main_q.wreg;
    assign wb_wdata = main_q.wdata;
    assign wb_hi    = main_q.hi;
    assign wb_lo    = main_q.lo;
    assign wb_whilo = main_q.whilo;

`ifdef MEMWB_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // saturating; flush deliberately leaves it alone
    always_comb begin
        cnt_d = cnt_q;
        if (main_v_q && !wb_ready && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
